// File: rtl/el2_pkg.sv
// Shared types, sizing constants and helpers for the branch-predictor training path.
package el2_pkg;

    localparam int BTB_ADDR_LO      = 2;
    localparam int BTB_ADDR_HI      = 9;
    localparam int IW               = BTB_ADDR_HI - BTB_ADDR_LO + 1;
    localparam int BTB_BTAG_SIZE    = 5;
    localparam int BTB_TOFFSET_SIZE = 12;
    localparam int BHT_GHR_SIZE     = 8;
    localparam int FIFO_DEPTH       = 4;

    localparam logic [1:0] STRONG_T  = 2'd3;
    localparam logic [1:0] STRONG_NT = 2'd0;

    // One buffered training update with hashes already resolved.
    typedef struct packed {
        logic [IW-1:0]               idx;
        logic [BTB_BTAG_SIZE-1:0]    tag;
        logic [IW-1:0]               bht_idx;
        logic [BTB_TOFFSET_SIZE-1:0] toffset;
        logic [1:0]                  ctr;
        logic                        btb_wen;
        logic                        btb_inv;
        logic                        bht_wen;
    } bp_upd_pkt_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        if (taken) begin
            if (ctr == STRONG_T) r = STRONG_T;
            else                 r = ctr + 2'd1;
        end else begin
            if (ctr == STRONG_NT) r = STRONG_NT;
            else                  r = ctr - 2'd1;
        end
        return r;
    endfunction

    // True when the entry carries at least one array write.
    function automatic logic pkt_has_write(input bp_upd_pkt_t p);
        return p.btb_wen | p.btb_inv | p.bht_wen;
    endfunction

endpackage

// File: rtl/el2_bp_train_ctl_if.sv
// Update-in / array-write-out bundle for the predictor training controller.
interface el2_bp_train_ctl_if;
    import el2_pkg::*;

    logic                        upd_valid;
    logic                        upd_ready;
    logic [31:1]                 upd_pc;
    logic                        upd_taken;
    logic                        upd_cond;
    logic                        upd_mispred;
    logic                        upd_btb_hit;
    logic                        upd_error;
    logic [1:0]                  upd_ctr;
    logic [BHT_GHR_SIZE-1:0]     upd_ghr;
    logic [BTB_TOFFSET_SIZE-1:0] upd_toffset;
    logic                        bp_flush;
    logic                        wr_valid;
    logic                        wr_ready;
    logic                        btb_wen;
    logic                        btb_inv;
    logic [IW-1:0]               btb_idx;
    logic [BTB_BTAG_SIZE-1:0]    btb_tag;
    logic [BTB_TOFFSET_SIZE-1:0] btb_toffset;
    logic                        bht_wen;
    logic [IW-1:0]               bht_idx;
    logic [1:0]                  bht_ctr;
    logic [BHT_GHR_SIZE-1:0]     ghr_commit;

    modport slave (
        input  upd_valid, upd_pc, upd_taken, upd_cond, upd_mispred, upd_btb_hit,
               upd_error, upd_ctr, upd_ghr, upd_toffset, bp_flush, wr_ready,
        output upd_ready, wr_valid, btb_wen, btb_inv, btb_idx, btb_tag, btb_toffset,
               bht_wen, bht_idx, bht_ctr, ghr_commit
    );

    modport master (
        output upd_valid, upd_pc, upd_taken, upd_cond, upd_mispred, upd_btb_hit,
               upd_error, upd_ctr, upd_ghr, upd_toffset, bp_flush, wr_ready,
        input  upd_ready, wr_valid, btb_wen, btb_inv, btb_idx, btb_tag, btb_toffset,
               bht_wen, bht_idx, bht_ctr, ghr_commit
    );

endinterface

// File: rtl/el2_bp_upd_fifo.sv
// Small synchronous FIFO of training packets; flush empties it in one cycle.
module el2_bp_upd_fifo
    import el2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  bp_upd_pkt_t din,
    input  logic        pop,
    output bp_upd_pkt_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra wrap bit on each pointer separates full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    bp_upd_pkt_t  mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage, cleared on reset so no stale packet is ever visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end else begin
            mem <= mem;
        end
    end

endmodule

// File: rtl/el2_bp_train_ctl.sv
// Branch predictor training controller: hashes resolved updates, buffers them,
// and drains BTB/BHT writes to the arrays while tracking the committed GHR.
module el2_bp_train_ctl
    import el2_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    el2_bp_train_ctl_if.slave  bus
);

    localparam int TAG_LO = BTB_ADDR_LO + IW;
    localparam int TS     = BTB_BTAG_SIZE;

    bp_upd_pkt_t in_pkt;
    bp_upd_pkt_t head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        head_write;
    logic [BHT_GHR_SIZE-1:0] ghr;
    logic        unused_pc;

    // PC bits that feed neither hash.
    assign unused_pc = ^{bus.upd_pc[31:BTB_ADDR_HI+2*IW+1], bus.upd_pc[BTB_ADDR_LO-1:1]};

    // No acceptance during a flush cycle; ready comes only from registered pointers.
    assign push          = bus.upd_valid && !full && !bus.bp_flush;
    assign bus.upd_ready = !full;

    // Build the stored packet: the lookup-side hashes plus the write decode.
    always_comb begin
        in_pkt         = '0;
        in_pkt.idx     = bus.upd_pc[BTB_ADDR_HI:BTB_ADDR_LO]
                       ^ bus.upd_pc[BTB_ADDR_HI+IW:BTB_ADDR_LO+IW]
                       ^ bus.upd_pc[BTB_ADDR_HI+2*IW:BTB_ADDR_LO+2*IW];
        in_pkt.tag     = bus.upd_pc[TAG_LO+TS-1:TAG_LO]
                       ^ bus.upd_pc[TAG_LO+2*TS-1:TAG_LO+TS]
                       ^ bus.upd_pc[TAG_LO+3*TS-1:TAG_LO+2*TS];
        in_pkt.bht_idx[BHT_GHR_SIZE-1:0] = in_pkt.idx[BHT_GHR_SIZE-1:0] ^ bus.upd_ghr;
        in_pkt.toffset = bus.upd_toffset;
        in_pkt.ctr     = next_ctr(bus.upd_ctr, bus.upd_taken);
        in_pkt.bht_wen = bus.upd_cond;
        in_pkt.btb_inv = bus.upd_error;
        in_pkt.btb_wen = !bus.upd_error && bus.upd_taken && (bus.upd_mispred || !bus.upd_btb_hit);
    end

    el2_bp_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (bus.bp_flush),
        .push  (push),
        .din   (in_pkt),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Head pops when its write is taken or when it carries nothing to write.
    always_comb begin
        head_write = 1'b0;
        pop        = 1'b0;
        if (!empty) begin
            head_write = pkt_has_write(head);
            pop        = (!head_write || bus.wr_ready) && !bus.bp_flush;
        end else begin
            head_write = 1'b0;
            pop        = 1'b0;
        end
    end

    // Array write outputs come straight from the stored head entry.
    always_comb begin
        bus.wr_valid    = head_write && !bus.bp_flush;
        bus.btb_wen     = 1'b0;
        bus.btb_inv     = 1'b0;
        bus.btb_idx     = '0;
        bus.btb_tag     = '0;
        bus.btb_toffset = '0;
        bus.bht_wen     = 1'b0;
        bus.bht_idx     = '0;
        bus.bht_ctr     = 2'd0;
        if (!empty) begin
            bus.btb_wen     = head.btb_wen;
            bus.btb_inv     = head.btb_inv;
            bus.btb_idx     = head.idx;
            bus.btb_tag     = head.tag;
            bus.btb_toffset = head.toffset;
            bus.bht_wen     = head.bht_wen;
            bus.bht_idx     = head.bht_idx;
            bus.bht_ctr     = head.ctr;
        end else begin
            bus.btb_wen     = 1'b0;
        end
    end

    // Committed GHR shifts in the direction of every accepted conditional branch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr <= '0;
        end else if (bus.bp_flush) begin
            ghr <= '0;
        end else if (push && bus.upd_cond) begin
            ghr <= {ghr[BHT_GHR_SIZE-2:0], bus.upd_taken};
        end else begin
            ghr <= ghr;
        end
    end

    assign bus.ghr_commit = ghr;

endmodule

// File: tb/tb_el2_bp_train_ctl.sv
// Directed, table-driven bench for el2_bp_train_ctl.
module tb_el2_bp_train_ctl;
    import el2_pkg::*;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    el2_bp_train_ctl_if bus ();

    el2_bp_train_ctl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic        cond, taken, mispred, hit, err;
        logic [1:0]  ctr;
        logic [7:0]  ghr;
        logic [11:0] toff;
        logic        e_valid, e_bwen, e_inv, e_hwen;
        logic [7:0]  e_idx;
        logic [4:0]  e_tag;
        logic [7:0]  e_hidx;
        logic [1:0]  e_ctr;
        logic [7:0]  e_ghr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic cond, input logic taken,
                         input logic mispred, input logic hit, input logic err,
                         input logic [1:0] ctr, input logic [7:0] ghr, input logic [11:0] toff);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = pc[31:1];
        bus.upd_cond    = cond;
        bus.upd_taken   = taken;
        bus.upd_mispred = mispred;
        bus.upd_btb_hit = hit;
        bus.upd_error   = err;
        bus.upd_ctr     = ctr;
        bus.upd_ghr     = ghr;
        bus.upd_toffset = toff;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_valid"}, 32'(bus.wr_valid), 32'd0);
        chk({tag, "_btb_wen"},  32'(bus.btb_wen),  32'd0);
        chk({tag, "_btb_inv"},  32'(bus.btb_inv),  32'd0);
        chk({tag, "_btb_idx"},  32'(bus.btb_idx),  32'd0);
        chk({tag, "_btb_tag"},  32'(bus.btb_tag),  32'd0);
        chk({tag, "_toffset"},  32'(bus.btb_toffset), 32'd0);
        chk({tag, "_bht_wen"},  32'(bus.bht_wen),  32'd0);
        chk({tag, "_bht_idx"},  32'(bus.bht_idx),  32'd0);
        chk({tag, "_bht_ctr"},  32'(bus.bht_ctr),  32'd0);
        chk({tag, "_upd_ready"}, 32'(bus.upd_ready), 32'd1);
        chk({tag, "_ghr"},      32'(bus.ghr_commit), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        // pc, cond,taken,mispred,hit,err, ctr, ghr, toff | valid,bwen,inv,hwen, idx, tag, hidx, ctr, ghr
        vecs[0] = '{32'h0000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h03, 12'h010,
                    1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 5'h00, 8'h01, 2'd2, 8'h01};
        vecs[1] = '{32'h0000_0404, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'hAA, 12'h123,
                    1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'h01, 8'hAA, 2'd3, 8'h03};
        vecs[2] = '{32'h0012_3456, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h0F, 12'hABC,
                    1'b1, 1'b0, 1'b0, 1'b1, 8'h9C, 5'h08, 8'h93, 2'd0, 8'h06};
        vecs[3] = '{32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 8'h00, 12'h7FF,
                    1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 5'h00, 8'h02, 2'd3, 8'h06};
        vecs[4] = '{32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h55, 12'hFFF,
                    1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 5'h1F, 8'hAA, 2'd2, 8'h06};
        vecs[5] = '{32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h02, 12'h001,
                    1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 5'h00, 8'h00, 2'd3, 8'h0D};

        reset = 1'b1;
        bus.bp_flush = 1'b0;
        bus.wr_ready = 1'b1;
        offer(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 12'h000);
        bus.upd_valid = 1'b0;
        step();
        chk_idle("reset");
        step();
        reset = 1'b0;
        step();

        // Single-update vectors: accept, check the write one cycle later, then drained.
        for (int i = 0; i < 6; i++) begin
            offer(vecs[i].pc, vecs[i].cond, vecs[i].taken, vecs[i].mispred, vecs[i].hit,
                  vecs[i].err, vecs[i].ctr, vecs[i].ghr, vecs[i].toff);
            step();
            bus.upd_valid = 1'b0;
            chk($sformatf("v%0d_wr_valid", i), 32'(bus.wr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_btb_wen", i),  32'(bus.btb_wen),  32'(vecs[i].e_bwen));
            chk($sformatf("v%0d_btb_inv", i),  32'(bus.btb_inv),  32'(vecs[i].e_inv));
            chk($sformatf("v%0d_bht_wen", i),  32'(bus.bht_wen),  32'(vecs[i].e_hwen));
            chk($sformatf("v%0d_btb_idx", i),  32'(bus.btb_idx),  32'(vecs[i].e_idx));
            chk($sformatf("v%0d_btb_tag", i),  32'(bus.btb_tag),  32'(vecs[i].e_tag));
            chk($sformatf("v%0d_bht_idx", i),  32'(bus.bht_idx),  32'(vecs[i].e_hidx));
            chk($sformatf("v%0d_bht_ctr", i),  32'(bus.bht_ctr),  32'(vecs[i].e_ctr));
            chk($sformatf("v%0d_toffset", i),  32'(bus.btb_toffset), 32'(vecs[i].toff));
            chk($sformatf("v%0d_ghr", i),      32'(bus.ghr_commit), 32'(vecs[i].e_ghr));
            step();
            chk($sformatf("v%0d_drained", i),  32'(bus.wr_valid), 32'd0);
        end

        // Backpressure: five offers against a stalled array port, four fit.
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(32'(8 * (i + 1)), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 12'(i));
            #1;
            chk($sformatf("bp_upd_ready%0d", i), 32'(bus.upd_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        bus.upd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("bp_hold_valid%0d", k), 32'(bus.wr_valid), 32'd1);
            chk($sformatf("bp_hold_idx%0d", k),   32'(bus.btb_idx),  32'h02);
            chk($sformatf("bp_hold_toff%0d", k),  32'(bus.btb_toffset), 32'h000);
            step();
        end
        bus.wr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp_drain_valid%0d", j), 32'(bus.wr_valid), 32'd1);
            chk($sformatf("bp_drain_idx%0d", j),   32'(bus.btb_idx),  32'(2 * (j + 1)));
            chk($sformatf("bp_drain_wen%0d", j),   32'(bus.btb_wen),  32'd1);
            step();
        end
        chk("bp_empty_valid", 32'(bus.wr_valid), 32'd0);
        chk("bp_empty_ready", 32'(bus.upd_ready), 32'd1);
        chk("bp_ghr", 32'(bus.ghr_commit), 32'h0D);

        // No-op entry must vanish within one cycle even with the port stalled.
        bus.wr_ready = 1'b0;
        offer(32'h0000_0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 12'h000);
        step();
        chk("noop_no_valid", 32'(bus.wr_valid), 32'd0);
        offer(32'h0000_0018, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 12'h055);
        step();
        bus.upd_valid = 1'b0;
        chk("noop_next_valid", 32'(bus.wr_valid), 32'd1);
        chk("noop_next_idx",   32'(bus.btb_idx),  32'h06);
        bus.wr_ready = 1'b1;
        step();
        chk("noop_drained", 32'(bus.wr_valid), 32'd0);

        // Flush collides with an offered update and a pending head.
        bus.wr_ready = 1'b0;
        offer(32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 12'h010);
        step();
        bus.upd_valid = 1'b0;
        chk("fl_pending_valid", 32'(bus.wr_valid), 32'd1);
        chk("fl_pending_ghr",   32'(bus.ghr_commit), 32'h1B);
        offer(32'h0000_0018, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 12'h020);
        bus.bp_flush = 1'b1;
        bus.wr_ready = 1'b1;
        #1;
        chk("fl_cycle_no_write", 32'(bus.wr_valid), 32'd0);
        step();
        bus.bp_flush  = 1'b0;
        bus.upd_valid = 1'b0;
        chk("fl_after_valid", 32'(bus.wr_valid), 32'd0);
        chk("fl_after_ghr",   32'(bus.ghr_commit), 32'd0);
        chk("fl_after_ready", 32'(bus.upd_ready), 32'd1);
        step();
        chk("fl_later_valid", 32'(bus.wr_valid), 32'd0);

        // Asynchronous reset in the middle of a stalled drain.
        bus.wr_ready = 1'b0;
        offer(32'h0000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h03, 12'h010);
        step();
        bus.upd_valid = 1'b0;
        chk("mr_pending_valid", 32'(bus.wr_valid), 32'd1);
        chk("mr_pending_ghr",   32'(bus.ghr_commit), 32'h01);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("midreset");
        step();
        reset = 1'b0;
        bus.wr_ready = 1'b1;
        step();
        chk("mr_after_valid", 32'(bus.wr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/el2_bp_train_ctl.md
Name: el2_bp_train_ctl

Overview:
- Write-side (training) controller for the branch predictor arrays; the lookup path reads those arrays through the BTB index, tag and GHR hashes.
- Accepts resolved-branch updates from the execute/commit stage and buffers them in a small FIFO.
- For each update it recomputes the same BTB index, BTB tag and BHT index hashes the lookup side uses, then issues BTB and BHT write requests to the arrays with a valid/ready handshake.
- Maintains the committed global history register (GHR) and exports it for front-end recovery.

Parameters:
- BTB_ADDR_LO, 2, low bit of the BTB index.
- BTB_ADDR_HI, 9, high bit of the BTB index; index width IW = HI-LO+1 = 8.
- BTB_BTAG_SIZE, 5, BTB tag width.
- BTB_TOFFSET_SIZE, 12, stored target-offset width.
- BHT_GHR_SIZE, 8, GHR width; must be <= IW.
- FIFO_DEPTH, 4, update buffer entries; power of two, >= 2.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- upd_valid  in  1  resolved-branch update offered.
- upd_ready  out  1  buffer can accept an update.
- upd_pc  in  31  branch PC [31:1].
- upd_taken  in  1  actual direction.
- upd_cond  in  1  conditional branch; only these train the BHT and GHR.
- upd_mispred  in  1  direction or target mispredicted.
- upd_btb_hit  in  1  the BTB hit at prediction time.
- upd_error  in  1  BTB hit on a non-branch.
- upd_ctr  in  2  BHT counter value read at prediction.
- upd_ghr  in  BHT_GHR_SIZE  GHR used at prediction.
- upd_toffset  in  BTB_TOFFSET_SIZE  actual target offset.
- bp_flush  in  1  predictor invalidate; clears FIFO and GHR.
- wr_valid  out  1  write request to the arrays.
- wr_ready  in  1  arrays accept this cycle.
- btb_wen  out  1  BTB write; entry made valid.
- btb_inv  out  1  BTB invalidate of the indexed entry.
- btb_idx  out  IW  BTB index.
- btb_tag  out  BTB_BTAG_SIZE  BTB tag.
- btb_toffset  out  BTB_TOFFSET_SIZE  target offset.
- bht_wen  out  1  BHT write.
- bht_idx  out  IW  BHT index.
- bht_ctr  out  2  new counter value.
- ghr_commit  out  BHT_GHR_SIZE  committed GHR.

Behaviour:
- Reset: all outputs 0 except upd_ready=1. FIFO empty, GHR=0.
- Accept: an update is enqueued when upd_valid && upd_ready.
  - upd_ready = !full, taken from registered state; no same-cycle bypass when full, even if the head drains that cycle.
  - Enqueue and dequeue may occur in the same cycle.
- Hashes, computed at enqueue and stored per entry:
  - btb_idx = pc[9:2] ^ pc[17:10] ^ pc[25:18].
  - btb_tag = pc[14:10] ^ pc[19:15] ^ pc[24:20].
  - bht_idx = btb_idx[GHR-1:0] ^ upd_ghr, zero-extended to IW.
- Counter: bht_ctr = taken ? min(ctr+1, 3) : max(ctr-1, 0).
- Write decode per entry:
  - bht_wen = cond.
  - btb_inv = error.
  - btb_wen = !error && taken && (mispred || !btb_hit).
  - An entry with no write enable set is dropped internally without asserting wr_valid.
- Drain:
  - wr_valid = FIFO head holds a write-bearing entry.
  - Outputs are driven directly from the head entry (registered storage), so minimum latency is accept at cycle N, wr_valid at N+1.
  - The head pops on wr_valid && wr_ready, or on a no-write entry.
  - While wr_ready=0, all wr_* outputs are held stable.
- GHR: on accept with cond=1, ghr_commit <= {ghr_commit[GHR-2:0], taken}.
- bp_flush: synchronous.
  - Next cycle: FIFO empty, GHR=0, wr_valid=0.
  - An update offered in the flush cycle is discarded, and any pop in that cycle is void.
- Pointers: log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
- Asserting reset mid-drain clears everything immediately. No partial write is repeated.

Decomposition:
- el2_pkg holds:
  - bp_upd_pkt_t (idx, tag, bht_idx, toffset, ctr, wen/inv flags).
  - The counter constants STRONG_T=3 and STRONG_NT=0.
- Sub-module: el2_bp_upd_fifo, a generic synchronous FIFO of bp_upd_pkt_t with flush.
- Hash logic stays inline.

Test Plan:
- Reset: assert reset mid-simulation -> all outputs 0, upd_ready=1, ghr_commit=0.
- Basic write: pc=0x00000008, cond=1, taken=1, mispred=1, btb_hit=0, ctr=1, ghr=0x03, toffset=0x010, wr_ready=1.
  - Next cycle: wr_valid=1, btb_wen=1, btb_idx=0x02, btb_tag=0, bht_idx=0x01, bht_ctr=2, btb_toffset=0x010.
  - ghr_commit=0x01.
- Saturation: ctr=3 with taken=1 -> bht_ctr=3; ctr=0 with taken=0 -> bht_ctr=0, btb_wen=0, wr_valid=1.
- Backpressure and full: wr_ready=0, offer 5 updates -> 4 accepted, upd_ready=0 on the 5th; wr_* outputs stable.
  - Release wr_ready -> 4 writes in order, one per cycle.
- Error and no-op: an error=1 entry -> btb_inv=1. A non-conditional update that is correctly predicted and BTB-hit -> no wr_valid, and the entry is dropped within 1 cycle.
- Flush collision: bp_flush together with upd_valid and a pending head -> next cycle FIFO empty, wr_valid=0, ghr_commit=0, and no write issued.
